// File: rtl/dmem_resp.sv
// Data-memory responder for the RV32 core data port: byte/half/word stores and extended loads.
// Latency: response pulse WAIT_CYCLES+1 cycles after the accepting cycle; one request per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready only in IDLE; no response backpressure. Build option: DMEM_MISALIGN_TRAP_EN.
module dmem_resp #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  DMType,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    logic               r_mem_w;
    logic [ADDR_W+1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [2:0]         r_dmtype;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [0:DEPTH-1];

    logic               w_accept;
    logic               w_commit;
    logic               w_a_mem_w;
    logic [ADDR_W+1:0]  w_a_addr;
    logic [31:0]        w_a_wdata;
    logic [2:0]         w_a_dmtype;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_signed;
    logic [1:0]         w_lane;
    logic [ADDR_W-1:0]  w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic [31:0]        w_rword;
    logic [31:0]        w_shift;
    logic [31:0]        w_ext;
    logic               w_err;
    logic [31-ADDR_W-2:0] w_unused_addr;

    assign w_unused_addr = addr[31:ADDR_W+2];

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // With zero wait states the array is accessed on the accepting edge, so use the live inputs.
    assign w_a_mem_w  = (WAIT_CYCLES == 0) ? mem_w             : r_mem_w;
    assign w_a_addr   = (WAIT_CYCLES == 0) ? addr[ADDR_W+1:0]  : r_addr;
    assign w_a_wdata  = (WAIT_CYCLES == 0) ? wdata             : r_wdata;
    assign w_a_dmtype = (WAIT_CYCLES == 0) ? DMType            : r_dmtype;

    assign w_commit = rst && ((WAIT_CYCLES == 0) ? w_accept
                                                 : ((r_state == S_WAIT) && (r_cnt == '0)));

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_cnt_next = CNT_INIT;
                    w_next     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_is_byte = (w_a_dmtype == 3'b011) || (w_a_dmtype == 3'b100);
        w_is_half = (w_a_dmtype == 3'b001) || (w_a_dmtype == 3'b010);
        w_signed  = (w_a_dmtype == 3'b011) || (w_a_dmtype == 3'b001);
        w_idx     = w_a_addr[ADDR_W+1:2];

        // Lane choice forces natural alignment; a trapped access never reaches the array anyway.
        if (w_is_byte) begin
            w_lane = w_a_addr[1:0];
            w_be   = 4'b0001 << w_lane;
            w_wd   = {4{w_a_wdata[7:0]}};
        end else if (w_is_half) begin
            w_lane = {w_a_addr[1], 1'b0};
            w_be   = 4'b0011 << w_lane;
            w_wd   = {2{w_a_wdata[15:0]}};
        end else begin
            w_lane = 2'b00;
            w_be   = 4'b1111;
            w_wd   = w_a_wdata;
        end

        w_rword = r_mem[w_idx];
        w_shift = w_rword >> {w_lane, 3'b000};
        if (w_is_byte) begin
            w_ext = {{24{w_signed & w_shift[7]}}, w_shift[7:0]};
        end else if (w_is_half) begin
            w_ext = {{16{w_signed & w_shift[15]}}, w_shift[15:0]};
        end else begin
            w_ext = w_rword;
        end

`ifdef DMEM_MISALIGN_TRAP_EN
        w_err = (w_is_half && w_a_addr[0]) ||
                (!w_is_byte && !w_is_half && (w_a_addr[1:0] != 2'b00));
`else
        w_err = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mem_w  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_dmtype <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_mem_w  <= mem_w;
                r_addr   <= addr[ADDR_W+1:0];
                r_wdata  <= wdata;
                r_dmtype <= DMType;
            end
            if (w_commit) begin
                r_err <= w_err;
                if (!w_a_mem_w && !w_err) begin
                    r_rdata <= w_ext;
                end
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_a_mem_w && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign rdata      = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: scoreboarded request/response sequence on a 2-wait-state instance,
// plus a zero-wait-state instance for back-to-back throughput.
module tb_dmem_resp;

    localparam int WAIT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, mem_w, resp_valid, resp_err;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  dmtype;
    logic        v0, rdy0, mw0, rv0, err0;
    logic [31:0] a0, wd0, rd0;
    logic [2:0]  dt0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   resp_count = 0;
    bit   inflight = 0;
    int   acc0 = 0;
    int   n_acc0 = 0;
    bit   seen0 = 0;
    bit   hold0 = 0;
    logic [31:0] exp_hold = '0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_resp #(.ADDR_W(8), .WAIT_CYCLES(WAIT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_w(mem_w), .addr(addr), .wdata(wdata), .DMType(dmtype),
        .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err)
    );

    dmem_resp #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
        .mem_w(mw0), .addr(a0), .wdata(wd0), .DMType(dt0),
        .resp_valid(rv0), .rdata(rd0), .resp_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                inflight = 0;
                seen0    = 0;
            end else begin
                if (inflight) chk("ready_low", 32'(req_ready), 32'd0);
                if (resp_valid) begin
                    chk("resp_expected", 32'(inflight), 32'd1);
                    chk("latency", 32'(cyc - acc_cyc), 32'(WAIT + 1));
                    chk("sb_underflow", 32'(sb.size() == 0), 32'd0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rdata", rdata, e.rd);
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                    end
                    inflight = 0;
                    resp_count++;
                end
                if (req_valid && req_ready) begin
                    inflight = 1;
                    acc_cyc  = cyc;
                end
                if (rv0) chk("lat0", 32'(cyc - acc0), 32'd1);
                if (v0 && rdy0) begin
                    if (hold0 && seen0) chk("gap0", 32'(cyc - acc0), 32'd2);
                    acc0  = cyc;
                    seen0 = 1;
                    n_acc0++;
                end
            end
        end
    end

    task automatic req(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] dt, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   rc0;
        bit   acc = 0;
        bit   got = 0;
        e.err = exp_err;
        e.rd  = (mw || exp_err) ? exp_hold : exp_rd;
        if (!mw && !exp_err) exp_hold = exp_rd;
        sb.push_back(e);
        rc0 = resp_count;
        @(posedge clk); #1;
        req_valid = 1'b1; mem_w = mw; addr = a; wdata = wd; dmtype = dt;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("accept_timeout", 32'(acc), 32'd1);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_count != rc0) got = 1;
        end
        chk("resp_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit got;
        rst = 1'b0; req_valid = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; dmtype = '0;
        v0 = 1'b0; mw0 = 1'b0; a0 = '0; wd0 = '0; dt0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b1;

        // Word store/load, byte lanes, halfword lanes.
        req(1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0, 1'b0);
        req(0, 32'h10, 32'h0, 3'b000, 32'hDEADBEEF, 1'b0);
        req(1, 32'h13, 32'h00000080, 3'b011, 32'h0, 1'b0);
        req(0, 32'h13, 32'h0, 3'b011, 32'hFFFFFF80, 1'b0);
        req(0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);
        req(0, 32'h10, 32'h0, 3'b000, 32'h80ADBEEF, 1'b0);
        req(0, 32'h11, 32'h0, 3'b011, 32'hFFFFFFBE, 1'b0);
        req(0, 32'h12, 32'h0, 3'b100, 32'h000000AD, 1'b0);
        req(0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
        req(0, 32'h410, 32'h0, 3'b000, 32'h80ADBEEF, 1'b0);
        req(1, 32'h20, 32'h0, 3'b000, 32'h0, 1'b0);
        req(1, 32'h22, 32'h00008001, 3'b001, 32'h0, 1'b0);
        req(0, 32'h22, 32'h0, 3'b001, 32'hFFFF8001, 1'b0);
        req(0, 32'h22, 32'h0, 3'b010, 32'h00008001, 1'b0);
        req(0, 32'h20, 32'h0, 3'b000, 32'h80010000, 1'b0);
        req(0, 32'h20, 32'h0, 3'b111, 32'h80010000, 1'b0);

        // Reset during the wait states of a store aborts it.
        req(1, 32'h40, 32'hCAFEF00D, 3'b000, 32'h0, 1'b0);
        req(0, 32'h40, 32'h0, 3'b000, 32'hCAFEF00D, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; mem_w = 1'b1; addr = 32'h40; wdata = 32'h12345678; dmtype = 3'b000;
        acc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_accept", 32'(acc), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        exp_hold = '0;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_err", 32'(resp_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        req(0, 32'h40, 32'h0, 3'b000, 32'hCAFEF00D, 1'b0);

        // Misaligned word accesses.
        req(1, 32'h41, 32'h11223344, 3'b000, 32'h0, TRAP);
        req(0, 32'h40, 32'h0, 3'b000, TRAP ? 32'hCAFEF00D : 32'h11223344, 1'b0);
        req(0, 32'h10, 32'h0, 3'b000, 32'h80ADBEEF, 1'b0);
        req(0, 32'h42, 32'h0, 3'b000, TRAP ? 32'hCAFEF00D : 32'h11223344, TRAP);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Zero wait states: valid held, accepts every second cycle.
        @(posedge clk); #1;
        hold0 = 1'b1;
        v0 = 1'b1; mw0 = 1'b1; a0 = 32'h8; wd0 = 32'hA5A5A5A5; dt0 = 3'b000;
        repeat (10) @(posedge clk);
        #1;
        v0 = 1'b0;
        hold0 = 1'b0;
        chk("acc0_count", 32'(n_acc0), 32'd5);
        @(posedge clk); #1;
        v0 = 1'b1; mw0 = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (rdy0) acc = 1;
        end
        @(posedge clk); #1;
        v0 = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rv0) got = 1;
        end
        chk("resp0_seen", 32'(got), 32'd1);
        chk("rdata0", rd0, 32'hA5A5A5A5);
        chk("err0", 32'(err0), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
